// File: rtl/pmem_pkg.sv
// Shared types and default parameters for the pmem block.
package pmem_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned DEPTH_DEF  = 32;
  localparam int unsigned RD_LAT_DEF = 1;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_e;

endpackage

// File: rtl/pmem_rd_pipe.sv
// Read-latency shift register of {valid, data}; each stage's data holds until a
// valid word arrives, so the last stage presents the most recent result.
module pmem_rd_pipe #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vld_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              vld_o,
  output logic [DATA_W-1:0] data_o
);

  logic [RD_LAT-1:0] vld_q;
  logic [DATA_W-1:0] data_q [RD_LAT];

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) data_q[i] <= '0;
    end else begin
      vld_q[0] <= vld_i;
      if (vld_i) data_q[0] <= data_i;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) data_q[i] <= data_q[i-1];
      end
    end
  end

  assign vld_o  = vld_q[RD_LAT-1];
  assign data_o = data_q[RD_LAT-1];

endmodule

// File: rtl/pmem.sv
// Single-port parameterised memory with a post-reset zeroing sweep, request
// rejection (err) and a fixed-latency pipelined read path.
module pmem
  import pmem_pkg::*;
#(
  parameter  int unsigned DATA_W = DATA_W_DEF,
  parameter  int unsigned DEPTH  = DEPTH_DEF,
  parameter  int unsigned RD_LAT = RD_LAT_DEF,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              busy,
  output logic              err
);

  localparam int unsigned ADDR_X = ADDR_W + 1;

  if (RD_LAT < 1 || RD_LAT > 4 || DEPTH < 2) begin : g_bad_param
    $error("pmem: RD_LAT must be 1-4 and DEPTH at least 2");
  end

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;
  logic              rd_acc;
  logic              addr_ok;
  logic [DATA_W-1:0] mem_q [DEPTH];

  assign addr_ok = {1'b0, addr} < ADDR_X'(DEPTH);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Sweep writes zeros while INIT; IDLE arbitrates and validates requests.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    mem_we  = 1'b0;
    mem_wa  = addr;
    mem_wd  = data_in;
    rd_acc  = 1'b0;
    case (state_q)
      ST_INIT: begin
        mem_we = 1'b1;
        mem_wa = cnt_q;
        mem_wd = '0;
        err_d  = read | write;
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      ST_IDLE: begin
        if (read || write) begin
          if ((read && write) || !addr_ok) begin
            err_d = 1'b1;
          end else if (write) begin
            mem_we = 1'b1;
          end else begin
            rd_acc = 1'b1;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Storage is deliberately unreset; the sweep defines its contents.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_wa] <= mem_wd;
  end

  pmem_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk    (clk),
    .reset  (reset),
    .vld_i  (rd_acc),
    .data_i (mem_q[addr]),
    .vld_o  (rd_valid),
    .data_o (data_out)
  );

  assign busy = (state_q == ST_INIT);
  assign err  = err_q;

endmodule

// File: tb/tb_pmem.sv
// Scoreboard bench driving two pmem instances (32x8 lat 1, 20x8 lat 3) in lockstep.
module tb_pmem;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       read = 1'b0;
  logic       write = 1'b0;
  logic [4:0] addr = '0;
  logic [7:0] din = '0;

  logic [7:0] dout0, dout1;
  logic       vld0, vld1, bsy0, bsy1, err0, err1;

  always #5 clk = ~clk;

  pmem #(.DATA_W(8), .DEPTH(32), .RD_LAT(1)) u_dut_a (
    .clk(clk), .reset(reset), .read(read), .write(write), .addr(addr),
    .data_in(din), .data_out(dout0), .rd_valid(vld0), .busy(bsy0), .err(err0)
  );

  pmem #(.DATA_W(8), .DEPTH(20), .RD_LAT(3)) u_dut_b (
    .clk(clk), .reset(reset), .read(read), .write(write), .addr(addr),
    .data_in(din), .data_out(dout1), .rd_valid(vld1), .busy(bsy1), .err(err1)
  );

  typedef struct {
    int         inst;
    int         due;
    logic [7:0] d;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mem_m [2][32];
  int         busy_left [2];
  logic       err_exp [2];
  logic [7:0] last_d [2];
  int         cyc = 0;
  int         n_assert = 0;
  int         n_fail = 0;

  function automatic int dep(input int i);
    return (i == 0) ? 32 : 20;
  endfunction

  function automatic int lat(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      busy_left[i] = dep(i);
      err_exp[i]   = 1'b0;
      last_d[i]    = 8'h00;
      for (int a = 0; a < 32; a++) mem_m[i][a] = 8'h00;
    end
    sb.delete();
  endtask

  task automatic check_outputs();
    for (int i = 0; i < 2; i++) begin
      string      sfx;
      logic       g_bsy, g_err, g_vld, e_vld;
      logic [7:0] g_dt;
      int         idx;
      sfx   = (i == 0) ? "_a" : "_b";
      g_bsy = (i == 0) ? bsy0 : bsy1;
      g_err = (i == 0) ? err0 : err1;
      g_vld = (i == 0) ? vld0 : vld1;
      g_dt  = (i == 0) ? dout0 : dout1;
      chk({"busy", sfx}, 32'(g_bsy), 32'(busy_left[i] > 0));
      chk({"err", sfx}, 32'(g_err), 32'(err_exp[i]));
      idx = -1;
      foreach (sb[k]) begin
        if (idx < 0 && sb[k].inst == i) idx = k;
      end
      e_vld = (idx >= 0) && (sb[idx].due == cyc);
      chk({"rd_valid", sfx}, 32'(g_vld), 32'(e_vld));
      if (idx >= 0 && sb[idx].due <= cyc) begin
        if (e_vld) last_d[i] = sb[idx].d;
        sb.delete(idx);
      end
      chk({"data_out", sfx}, 32'(g_dt), 32'(last_d[i]));
    end
  endtask

  // One clock: check what the last edge produced, then drive and predict the next edge.
  task automatic cycle(input logic rst, input logic rd, input logic wr,
                       input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    cyc++;
    check_outputs();
    reset = rst;
    read  = rd;
    write = wr;
    addr  = a;
    din   = d;
    if (rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < 2; i++) begin
        logic bad;
        bad = (busy_left[i] > 0) || (rd && wr) || (int'(a) >= dep(i));
        err_exp[i] = (rd || wr) && bad;
        if (!bad && wr) mem_m[i][a] = d;
        if (!bad && rd) sb.push_back('{i, cyc + lat(i), mem_m[i][a]});
        if (busy_left[i] > 0) busy_left[i]--;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
  endtask

  initial begin
    int na, nb;
    model_reset();
    cycle(1'b1, 1'b0, 1'b0, 5'd0, 8'h00);
    cycle(1'b1, 1'b0, 1'b0, 5'd0, 8'h00);

    // Sweep length, with a write to 7 while still busy
    na = 0;
    nb = 0;
    for (int k = 0; k < 40; k++) begin
      if (k == 5) cycle(1'b0, 1'b0, 1'b1, 5'd7, 8'hEE);
      else        cycle(1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
      if (bsy0) na++;
      if (bsy1) nb++;
    end
    chk("busy_len_a", 32'(na), 32'd32);
    chk("busy_len_b", 32'(nb), 32'd20);

    cycle(1'b0, 1'b1, 1'b0, 5'd31, 8'h00);
    cycle(1'b0, 1'b1, 1'b0, 5'd7, 8'h00);
    cycle(1'b0, 1'b0, 1'b1, 5'd3, 8'hA5);
    cycle(1'b0, 1'b1, 1'b0, 5'd3, 8'h00);
    idle(2);

    cycle(1'b0, 1'b0, 1'b1, 5'd0, 8'h11);
    cycle(1'b0, 1'b0, 1'b1, 5'd1, 8'h22);
    cycle(1'b0, 1'b0, 1'b1, 5'd2, 8'h33);
    cycle(1'b0, 1'b1, 1'b0, 5'd0, 8'h00);
    cycle(1'b0, 1'b1, 1'b0, 5'd1, 8'h00);
    cycle(1'b0, 1'b1, 1'b0, 5'd2, 8'h00);
    idle(4);

    cycle(1'b0, 1'b1, 1'b1, 5'd5, 8'h77);
    cycle(1'b0, 1'b0, 1'b1, 5'd25, 8'h99);
    cycle(1'b0, 1'b1, 1'b0, 5'd5, 8'h00);
    cycle(1'b0, 1'b1, 1'b0, 5'd25, 8'h00);
    cycle(1'b0, 1'b0, 1'b1, 5'd19, 8'h5A);
    cycle(1'b0, 1'b1, 1'b0, 5'd19, 8'h00);
    cycle(1'b0, 1'b1, 1'b0, 5'd20, 8'h00);
    idle(4);

    for (int k = 0; k < 300; k++) begin
      int op;
      op = int'($urandom_range(0, 9));
      cycle(1'b0, (op >= 2 && op <= 5) || op == 9, op >= 6,
            5'($urandom_range(0, 31)), 8'($urandom));
    end
    idle(4);

    // Reset with reads in flight, then confirm the sweep zeroed everything
    cycle(1'b0, 1'b1, 1'b0, 5'd3, 8'h00);
    cycle(1'b0, 1'b1, 1'b0, 5'd1, 8'h00);
    cycle(1'b1, 1'b0, 1'b0, 5'd0, 8'h00);
    cycle(1'b1, 1'b0, 1'b0, 5'd0, 8'h00);
    idle(40);
    cycle(1'b0, 1'b1, 1'b0, 5'd3, 8'h00);
    cycle(1'b0, 1'b1, 1'b0, 5'd1, 8'h00);
    cycle(1'b0, 1'b1, 1'b0, 5'd19, 8'h00);
    idle(6);

    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pmem.md
PMEM -- requirements
Module: pmem

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the data word width in bits.
REQ-002 Parameter DEPTH, default 32, SHALL set the number of words (2 or more, need not be a power of 2).
REQ-003 Parameter RD_LAT, default 1, SHALL set the read latency in clocks (legal range 1-4).
REQ-004 Derived constant ADDR_W = $clog2(DEPTH) SHALL set the address width.
REQ-005 clk  in  1  SHALL be the only clock; all state SHALL update on its rising edge.
REQ-006 reset  in  1  SHALL be the synchronous, active-high reset.
REQ-007 read  in  1  SHALL be the read request, sampled each clk.
REQ-008 write  in  1  SHALL be the write request, sampled each clk.
REQ-009 addr  in  ADDR_W  SHALL be the word address.
REQ-010 data_in  in  DATA_W  SHALL be the write data.
REQ-011 data_out  out  DATA_W  SHALL be the read data, qualified by rd_valid.
REQ-012 rd_valid  out  1  SHALL pulse high for one cycle, RD_LAT cycles after an accepted read.
REQ-013 busy  out  1  SHALL be high while the post-reset initialisation sweep runs.
REQ-014 err  out  1  SHALL pulse high for one cycle when a request is rejected.

Function
REQ-015 The FSM SHALL have two states: INIT and IDLE; reset SHALL force INIT.
REQ-016 INIT: the sweep counter SHALL write 0 to addresses 0..DEPTH-1, one per cycle, then go to IDLE; busy=1 for exactly DEPTH cycles.
REQ-017 IDLE, write=1, read=0, addr<DEPTH: memory[addr] SHALL take data_in at that edge.
REQ-018 IDLE, read=1, write=0, addr<DEPTH: the read SHALL be accepted; data_out SHALL equal memory[addr] as sampled at that edge, presented RD_LAT cycles later with rd_valid=1.
REQ-019 Back-to-back reads SHALL be accepted every cycle (full throughput); results SHALL return in issue order.
REQ-020 A read accepted on the cycle after a write to the same address SHALL return the newly written data.
REQ-021 read=1 and write=1 together SHALL perform no access and SHALL assert err.
REQ-022 addr>=DEPTH with read or write SHALL perform no access and SHALL assert err.
REQ-023 Any read or write while busy=1 SHALL be dropped and SHALL assert err.
REQ-024 data_out SHALL hold its last value while rd_valid=0.
REQ-025 Idle cycles (read=0, write=0) SHALL change no memory word and assert no err.

Reset
REQ-026 During reset the outputs SHALL be: data_out=0, rd_valid=0, err=0, busy=1.
REQ-027 Reset mid-operation SHALL clear all in-flight read valids (no rd_valid from pre-reset reads) and SHALL restart the sweep at address 0.
REQ-028 Memory contents SHALL be undefined only until the sweep completes; after that every word SHALL read 0 until written.

Structure
REQ-029 Package pmem_pkg SHALL hold the FSM state typedef (INIT, IDLE) and the default constants for DATA_W, DEPTH and RD_LAT.
REQ-030 The read-latency stage SHALL be the sub-module pmem_rd_pipe: a RD_LAT-deep shift register of {valid, data} with synchronous reset of valid.
REQ-031 An elaboration-time check SHALL reject RD_LAT outside 1-4 and DEPTH<2.

Verification
REQ-032 Reset for 2 cycles, release -> busy=1 for exactly 32 cycles; then a read of addr 31 -> data_out=0x00, rd_valid after RD_LAT.
REQ-033 Write 0xA5@3, then read @3 on the next cycle, with RD_LAT=3 -> rd_valid and data_out=0xA5 exactly 3 cycles after the read.
REQ-034 Reads @0,1,2 on consecutive cycles after writes 0x11,0x22,0x33 -> three consecutive rd_valid pulses carrying 0x11, 0x22, 0x33 in that order.
REQ-035 read=write=1 @5, and with DEPTH=20 a write @25 -> err pulses, memory[5] unchanged, no rd_valid.
REQ-036 Reset asserted with 2 reads in flight -> no rd_valid after reset; busy reasserts; memory reads 0 after the sweep.
REQ-037 Write during busy -> err=1 and the word still reads 0 after the sweep.
